serial_adder: RTL

- Bit-serial, LSB-first adder. One `full_adder_structural` bit cell (ports A, B, Cin, Sum, Carry) plus a carry flip-flop, operand/result shift registers and a small FSM.
- Trades WIDTH clock cycles for a single-cell datapath.
- Sits downstream of the full-adder cell as the area-minimal multi-bit adder for datapaths that tolerate latency.

---
 rtl/serial_adder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder: bit-serial adder that processes the LSB first. The datapath is
// a single full_adder_structural cell plus a carry flop. Each operation takes
// WIDTH bit cycles in RUN, followed by one DONE cycle.
//
// Build option: define SERIAL_ADDER_SUB_EN to enable subtraction. When it is
// enabled, an accepted Start with Sub=1 loads ~B and a carry of 1, so the
// result is A - B.
//
// Ports (serial_adder):
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   Start     request; sampled only in IDLE
//   A, B      WIDTH-bit operands, captured on the accepting edge
//   Cin       carry-in, captured on the accepting edge
//   Sub       subtract request (used only with SERIAL_ADDER_SUB_EN)
//   Busy      high while bits are being processed
//   Done      one-cycle completion pulse
//   Sum       registered result; holds until the next completion
//   Carry     registered carry-out of the MSB
//   Overflow  registered signed overflow
//
// Ports (full_adder_structural):
//   A, B, Cin  bit inputs;  Sum, Carry  bit outputs
// ----------------------------------------------------------------------------

module full_adder_structural (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Carry
);
    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x1 (ab_x, A, B);
    xor g_x2 (Sum, ab_x, Cin);
    and g_a1 (ab_a, A, B);
    and g_a2 (cx_a, ab_x, Cin);
    or  g_o1 (Carry, ab_a, cx_a);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q,  a_sr_d;
    logic [WIDTH-1:0]  b_sr_q,  b_sr_d;
    logic [WIDTH-1:0]  res_sr_q, res_sr_d;
    logic              cy_q,    cy_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]  sum_q,   sum_d;
    logic              cout_q,  cout_d;
    logic              ovf_q,   ovf_d;

    logic              cell_sum;
    logic              cell_carry;
    logic [WIDTH-1:0]  res_shift;

    full_adder_structural u_cell (
        .A     (a_sr_q[0]),
        .B     (b_sr_q[0]),
        .Cin   (cy_q),
        .Sum   (cell_sum),
        .Carry (cell_carry)
    );

`ifndef SERIAL_ADDER_SUB_EN
    logic unused_sub;
    assign unused_sub = Sub;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        // The new result bit enters at the MSB. Written as a shift plus a bit
        // write so that it also works when WIDTH = 1.
        res_shift            = res_sr_q >> 1;
        res_shift[WIDTH-1]   = cell_sum;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = RUN;
                    a_sr_d  = A;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    b_sr_d  = Sub ? ~B : B;
                    cy_d    = Sub ? 1'b1 : Cin;
`else
                    b_sr_d  = B;
                    cy_d    = Cin;
`endif
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shift;
                cy_d     = cell_carry;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = res_shift;
                    cout_d  = cell_carry;
                    // cy_q is the carry into the MSB during the last bit cycle.
                    ovf_d   = cy_q ^ cell_carry;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy     = (state_q == RUN);
    assign Done     = (state_q == DONE);
    assign Sum      = sum_q;
    assign Carry    = cout_q;
    assign Overflow = ovf_q;
endmodule
